// File: rtl/mshr_update_sched_pkg.sv
// Shared MSHR types for the update-port scheduler: entry/index types, table size
// and request kinds.
package mshr_update_sched_pkg;

    localparam int MSHR_SIZE  = 8;
    localparam int MSHR_IDX_W = $clog2(MSHR_SIZE);
    localparam int MSHR_CNT_W = $clog2(MSHR_SIZE + 1);

    typedef logic [MSHR_IDX_W-1:0] mshr_idx_t;

    typedef struct packed {
        logic        valid;
        logic        dirty;
        logic [1:0]  state;
        logic [11:0] line_tag;
    } mshr_entry_t;

    typedef enum logic [1:0] {
        MSHR_REQ_ALLOC   = 2'b00,
        MSHR_REQ_UPDATE  = 2'b01,
        MSHR_REQ_DEALLOC = 2'b10,
        MSHR_REQ_ILLEGAL = 2'b11
    } mshr_req_kind_t;

    // Alloc always writes a live entry and dealloc always kills it.
    function automatic mshr_entry_t force_valid(input mshr_entry_t e, input mshr_req_kind_t k);
        mshr_entry_t r;
        r = e;
        if (k == MSHR_REQ_ALLOC)
            r.valid = 1'b1;
        else if (k == MSHR_REQ_DEALLOC)
            r.valid = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/mshr_update_sched_if.sv
// Requester-side and MSHR update-port signals of the scheduler.
// master = requesters/MSHR environment, slave = the scheduler.
interface mshr_update_sched_if
    import mshr_update_sched_pkg::*;
#(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0] req_valid;
    mshr_req_kind_t     req_kind  [NUM_REQ];
    mshr_idx_t          req_index [NUM_REQ];
    mshr_entry_t        req_entry [NUM_REQ];
    logic [NUM_REQ-1:0] req_ready;
    mshr_idx_t          alloc_index;
    logic               mshr_full;
    logic               update_en;
    mshr_idx_t          update_index;
    mshr_entry_t        update_entry;

    modport master (
        output req_valid, req_kind, req_index, req_entry, mshr_full,
        input  req_ready, alloc_index, update_en, update_index, update_entry
    );

    modport slave (
        input  req_valid, req_kind, req_index, req_entry, mshr_full,
        output req_ready, alloc_index, update_en, update_index, update_entry
    );
endinterface

// File: rtl/mshr_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among eligible requesters starting at rr_ptr;
// the pointer moves past the winner and holds when nothing is granted.
module mshr_sched_rr_arbiter #(
    parameter int N = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         eligible,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id
);
    localparam int PTR_W = $clog2(N);

    logic [PTR_W-1:0] rr_ptr;

    always_comb begin
        int   idx;
        logic found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N)
                idx = idx - N;
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = PTR_W'(idx);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= '0;
        else if (|grant)
            rr_ptr <= (grant_id == PTR_W'(N - 1)) ? '0 : grant_id + 1'b1;
    end
endmodule

// File: rtl/priority_encoder_npu.sv
// LSB-first priority encoder: enc_index is the lowest set bit of in_vec.
module priority_encoder_npu #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         in_vec,
    output logic [$clog2(WIDTH)-1:0] enc_index,
    output logic                     valid
);
    localparam int IDX_W = $clog2(WIDTH);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        enc_index = '0;
        valid     = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                enc_index = IDX_W'(i);
                valid     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mshr_update_sched.sv
// MSHR update-port scheduler: round-robin grant of alloc/update/dealloc, entry
// ownership via an occupancy bitmap, registered update triple. Optional checker: MSHR_SCHED_CHECK_EN.
module mshr_update_sched
    import mshr_update_sched_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int ALLOC_COOLDOWN = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    mshr_update_sched_if.slave    bus,
    output logic [MSHR_CNT_W-1:0] occupied_count,
    output logic                  protocol_error
);
    localparam int CD_W = $clog2(ALLOC_COOLDOWN + 2);

    logic [MSHR_SIZE-1:0]       occ;
    logic [CD_W-1:0]            cooldown;
    mshr_idx_t                  free_idx;
    logic                       free_avail;
    logic                       alloc_ok;
    logic [NUM_REQ-1:0]         eligible;
    logic [NUM_REQ-1:0]         grant;
    logic [$clog2(NUM_REQ)-1:0] grant_id;
    logic                       any_grant;
    logic                       alloc_grant;
    mshr_req_kind_t             g_kind;
    mshr_idx_t                  g_index;
    mshr_idx_t                  tgt_idx;

    priority_encoder_npu #(.WIDTH(MSHR_SIZE)) u_free (
        .in_vec    (~occ),
        .enc_index (free_idx),
        .valid     (free_avail)
    );

    // A stalled alloc simply drops out of the eligible set, so it never holds the rr slot.
    assign alloc_ok = free_avail & ~bus.mshr_full & (cooldown == '0);

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++)
            eligible[i] = ~reset & bus.req_valid[i]
                        & (bus.req_kind[i] != MSHR_REQ_ILLEGAL)
                        & ((bus.req_kind[i] != MSHR_REQ_ALLOC) | alloc_ok);
    end

    mshr_sched_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk      (clk),
        .reset    (reset),
        .eligible (eligible),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign bus.req_ready   = grant;
    assign bus.alloc_index = free_idx;
    assign any_grant       = |grant;
    assign g_kind          = bus.req_kind[grant_id];
    assign g_index         = bus.req_index[grant_id];
    assign alloc_grant     = any_grant & (g_kind == MSHR_REQ_ALLOC);
    assign tgt_idx         = alloc_grant ? free_idx : g_index;
    assign occupied_count  = MSHR_CNT_W'($countones(occ));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ              <= '0;
            cooldown         <= '0;
            bus.update_en    <= 1'b0;
            bus.update_index <= '0;
            bus.update_entry <= '0;
        end else begin
            bus.update_en <= any_grant;
            if (any_grant) begin
                bus.update_index <= tgt_idx;
                bus.update_entry <= force_valid(bus.req_entry[grant_id], g_kind);
            end
            if (alloc_grant)
                occ[free_idx] <= 1'b1;
            else if (any_grant && g_kind == MSHR_REQ_DEALLOC)
                occ[g_index] <= 1'b0;
            if (alloc_grant)
                cooldown <= CD_W'(ALLOC_COOLDOWN);
            else if (cooldown != '0)
                cooldown <= cooldown - 1'b1;
        end
    end

`ifdef MSHR_SCHED_CHECK_EN
    logic illegal_seen;
    logic err_set;

    always_comb begin
        illegal_seen = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            if (bus.req_valid[i] && bus.req_kind[i] == MSHR_REQ_ILLEGAL)
                illegal_seen = 1'b1;
    end

    assign err_set = illegal_seen
                   | (any_grant & ~alloc_grant & ~occ[g_index])
                   | (alloc_grant & ~free_avail);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            protocol_error <= 1'b0;
        else if (err_set)
            protocol_error <= 1'b1;
    end

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (!reset && err_set)
            $error("mshr_update_sched: protocol error");
    end
`endif
`else
    assign protocol_error = 1'b0;
`endif

endmodule
